// File: rtl/divider32_seq.sv
// Iterative 32-bit restoring divider (DIV/DIVU), one quotient bit per clock.
// Define DIVIDER32_SIGNED_EN to honour the Signed input; otherwise every operation is DIVU.
module divider32_seq (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder,
  output logic        DivByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  state_t      state_r;
  logic [31:0] q_r;
  logic [31:0] rem_r;
  logic [31:0] div_r;
  logic [4:0]  cnt_r;
  logic        zero_r;

  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [32:0] shifted_s;
  logic [32:0] trial_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;

`ifdef DIVIDER32_SIGNED_EN
  logic sa_s;
  logic sb_s;
  logic sa_r;
  logic sb_r;

  // Operand signs and magnitudes at the Start edge; signs count only for DIV.
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    if (Signed) begin
      sa_s = A[31];
      sb_s = B[31];
    end else begin
      sa_s = 1'b0;
      sb_s = 1'b0;
    end
    abs_a_s = sa_s ? neg32(A) : A;
    abs_b_s = sb_s ? neg32(B) : B;
  end

  // Post-correction: truncating division, remainder follows the dividend sign.
  always_comb begin
    q_fix_s = (sa_r ^ sb_r) ? neg32(q_r) : q_r;
    r_fix_s = sa_r ? neg32(rem_r) : rem_r;
  end

  // Sign flags captured alongside the operands.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sa_r <= 1'b0;
      sb_r <= 1'b0;
    end else if (state_r == IDLE && Start) begin
      sa_r <= sa_s;
      sb_r <= sb_s;
    end else begin
      sa_r <= sa_r;
      sb_r <= sb_r;
    end
  end
`else
  logic unused_signed_s;
  assign unused_signed_s = Signed;

  // Unsigned-only build: operands pass through untouched.
  always_comb begin
    abs_a_s = A;
    abs_b_s = B;
    q_fix_s = q_r;
    r_fix_s = rem_r;
  end
`endif

  // One restoring step: shift {rem, q} left and try subtracting the divisor in 33 bits.
  always_comb begin
    shifted_s = {rem_r, q_r[31]};
    trial_s   = shifted_s - {1'b0, div_r};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      q_r       <= 32'd0;
      rem_r     <= 32'd0;
      div_r     <= 32'd0;
      cnt_r     <= 5'd0;
      zero_r    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= 32'd0;
      Remainder <= 32'd0;
      DivByZero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Busy  <= 1'b1;
            q_r   <= abs_a_s;
            div_r <= abs_b_s;
            cnt_r <= 5'd0;
            if (B == 32'd0) begin
              // Raw dividend parked in rem so FIX can return it unmodified.
              zero_r  <= 1'b1;
              rem_r   <= A;
              state_r <= FIX;
            end else begin
              zero_r  <= 1'b0;
              rem_r   <= 32'd0;
              state_r <= ITER;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          Done  <= 1'b0;
          rem_r <= trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
          q_r   <= {q_r[30:0], ~trial_s[32]};
          if (cnt_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        FIX: begin
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state_r <= IDLE;
          if (zero_r) begin
            Quotient  <= 32'hFFFF_FFFF;
            Remainder <= rem_r;
            DivByZero <= 1'b1;
          end else begin
            Quotient  <= q_fix_s;
            Remainder <= r_fix_s;
            DivByZero <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider32_seq.sv
// Directed self-checking bench for divider32_seq; expectations follow DIVIDER32_SIGNED_EN.
module tb_divider32_seq;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  int n_checks = 0;
  int n_fail = 0;

  divider32_seq dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  // Drive a Start request; returns 1 time unit after the sampling edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge Clk);
    A = a; B = b; Signed = s; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Count clocks until Done, bounded at 100.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 100) begin
      @(posedge Clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (Quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q: got %h want 0", Quotient); end
    n_checks++; if (Remainder !== 32'd0) begin n_fail++; $display("FAIL reset_r: got %h want 0", Remainder); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    start_op(32'd100, 32'd7, 1'b0);
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL u_busy: got %b want 1", Busy); end
    wait_done(lat);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL u_latency: got %0d want 33", lat); end
    n_checks++; if (Quotient !== 32'd14) begin n_fail++; $display("FAIL u_q: got %h want e", Quotient); end
    n_checks++; if (Remainder !== 32'd2) begin n_fail++; $display("FAIL u_r: got %h want 2", Remainder); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL u_dbz: got %b want 0", DivByZero); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL u_busy_done: got %b want 0", Busy); end
    @(posedge Clk); #1;
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL u_done_fall: got %b want 0", Done); end
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
`ifdef DIVIDER32_SIGNED_EN
    exp_q = 32'hFFFF_FFFD; exp_r = 32'hFFFF_FFFF;
`else
    exp_q = 32'h7FFF_FFFC; exp_r = 32'd1;
`endif
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat);
    n_checks++; if (Quotient !== exp_q) begin n_fail++; $display("FAIL s_q: got %h want %h", Quotient, exp_q); end
    n_checks++; if (Remainder !== exp_r) begin n_fail++; $display("FAIL s_r: got %h want %h", Remainder, exp_r); end
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(lat);
    n_checks++; if (Quotient !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL su_q: got %h want 7ffffffc", Quotient); end
    n_checks++; if (Remainder !== 32'd1) begin n_fail++; $display("FAIL su_r: got %h want 1", Remainder); end
`ifdef DIVIDER32_SIGNED_EN
    exp_q = 32'hFFFF_FFFE; exp_r = 32'd1;
`else
    exp_q = 32'd0; exp_r = 32'd7;
`endif
    start_op(32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_done(lat);
    n_checks++; if (Quotient !== exp_q) begin n_fail++; $display("FAIL s2_q: got %h want %h", Quotient, exp_q); end
    n_checks++; if (Remainder !== exp_r) begin n_fail++; $display("FAIL s2_r: got %h want %h", Remainder, exp_r); end
  endtask

  task automatic test_div_by_zero();
    int lat;
    start_op(32'd5, 32'd0, 1'b0);
    wait_done(lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL z_latency: got %0d want 1", lat); end
    n_checks++; if (Quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z_q: got %h want ffffffff", Quotient); end
    n_checks++; if (Remainder !== 32'd5) begin n_fail++; $display("FAIL z_r: got %h want 5", Remainder); end
    n_checks++; if (DivByZero !== 1'b1) begin n_fail++; $display("FAIL z_dbz: got %b want 1", DivByZero); end
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if (DivByZero !== 1'b1 || Quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z_hold: got dbz=%b q=%h want 1 ffffffff", DivByZero, Quotient); end
    start_op(32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done(lat);
    n_checks++; if (Remainder !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL zs_r: got %h want fffffff9", Remainder); end
    start_op(32'd9, 32'd3, 1'b0);
    n_checks++; if (DivByZero !== 1'b1) begin n_fail++; $display("FAIL z_not_cleared_at_start: got %b want 1", DivByZero); end
    wait_done(lat);
    n_checks++; if (Quotient !== 32'd3) begin n_fail++; $display("FAIL z2_q: got %h want 3", Quotient); end
    n_checks++; if (Remainder !== 32'd0) begin n_fail++; $display("FAIL z2_r: got %h want 0", Remainder); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL z2_dbz: got %b want 0", DivByZero); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
`ifdef DIVIDER32_SIGNED_EN
    exp_q = 32'h8000_0000; exp_r = 32'd0;
`else
    exp_q = 32'd0; exp_r = 32'h8000_0000;
`endif
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    n_checks++; if (Quotient !== exp_q) begin n_fail++; $display("FAIL ovf_q: got %h want %h", Quotient, exp_q); end
    n_checks++; if (Remainder !== exp_r) begin n_fail++; $display("FAIL ovf_r: got %h want %h", Remainder, exp_r); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b want 0", DivByZero); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int dones;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl: got busy=%b done=%b want 0 0", Busy, Done); end
    n_checks++; if (Quotient !== 32'd0 || Remainder !== 32'd0 || DivByZero !== 1'b0) begin n_fail++; $display("FAIL rm_outs: got q=%h r=%h dbz=%b want 0", Quotient, Remainder, DivByZero); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1 if (Done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d want 0", dones); end
    start_op(32'd1000, 32'd3, 1'b0);
    wait_done(lat);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rm_latency: got %0d want 33", lat); end
    n_checks++; if (Quotient !== 32'd333 || Remainder !== 32'd1) begin n_fail++; $display("FAIL rm_result: got %h/%h want 14d/1", Quotient, Remainder); end
  endtask

  task automatic test_start_while_busy();
    int dones;
    int lat;
    start_op(32'd50, 32'd5, 1'b0);
    dones = 0;
    lat = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge Clk);
      A = 32'd9; B = 32'd2; Start = 1'b1;
      @(posedge Clk);
      #1 if (Done) begin dones++; lat = k; end
    end
    Start = 1'b0;
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL sb_latency: got %0d want 33", lat); end
    n_checks++; if (Quotient !== 32'd10 || Remainder !== 32'd0) begin n_fail++; $display("FAIL sb_result: got %h/%h want a/0", Quotient, Remainder); end
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1 if (Done) dones++;
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL sb_done_count: got %0d want 1", dones); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle: got %b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'd20, 32'd3, 1'b0);
    wait_done(lat);
    n_checks++; if (Quotient !== 32'd6 || Remainder !== 32'd2) begin n_fail++; $display("FAIL bb_first: got %h/%h want 6/2", Quotient, Remainder); end
    A = 32'd7; B = 32'd7; Signed = 1'b0; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL bb_busy: got %b want 1", Busy); end
    wait_done(lat);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL bb_latency: got %0d want 33", lat); end
    n_checks++; if (Quotient !== 32'd1 || Remainder !== 32'd0) begin n_fail++; $display("FAIL bb_second: got %h/%h want 1/0", Quotient, Remainder); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_reset_mid_op();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
